instr_fetch: RTL



---
 rtl/core_pkg.sv | 21 ++
 rtl/instr_mem.sv | 34 +++
 rtl/instr_fetch.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch stage and its neighbours.
package core_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FETCH,
      ST_EXEC,
      ST_FAULT
   } fetch_state_e;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_OPIMMW = 7'h1B;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_BRANCH = 7'h63;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: single write port, synchronous read into a resettable
// output register that doubles as the instruction register.
module instr_mem
   import core_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 256,
   localparam int unsigned AW = $clog2(IMEM_DEPTH)
) (
   input  logic          clk_i,
   input  logic          cntrst_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [31:0]   wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [31:0]   rd_data_o
);

   logic [31:0] mem [IMEM_DEPTH];

   // Array is deliberately left out of reset so contents survive a core reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i)
         mem[wr_addr_i] <= wr_data_i;
   end

   always_ff @(posedge clk_i or negedge cntrst_i) begin
      if (!cntrst_i)
         rd_data_o <= '0;
      else if (rd_en_i)
         rd_data_o <= mem[rd_addr_i];
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: program counter, boot loader into instruction memory,
// instruction register decode fields and next-PC selection.
module instr_fetch
   import core_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic        clk_i,
   input  logic        cntrst_i,
   input  logic        iwr_en_i,
   input  logic        iwr_valid_i,
   input  logic [31:0] iwr_data_i,
   input  logic        run_i,
   input  logic        stall_i,
   input  logic        BE_i,
   input  logic        br_taken_i,
   input  logic        JALRE_i,
   input  logic        UJE_i,
   input  logic [31:0] imm_i,
   input  logic [31:0] jalr_tgt_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] instr_o,
   output logic [6:0]  opcode_o,
   output logic [2:0]  func3_o,
   output logic [6:0]  func7_o,
   output logic [4:0]  rd_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic        instr_valid_o,
   output logic        load_full_o,
   output logic        fault_o
);

   localparam int unsigned AW      = $clog2(IMEM_DEPTH);
   localparam logic [31:0] PC_SPAN = 32'(4 * IMEM_DEPTH);
   localparam logic [AW:0] PTR_END = (AW+1)'(IMEM_DEPTH);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [AW:0]  ptr_q, ptr_d;
   logic [31:0]  next_pc, pc_off;
   logic         next_bad;
   logic         mem_we, mem_re;
   logic         tgt_unused;

   assign tgt_unused = jalr_tgt_i[0];

   always_comb begin
      if (JALRE_i)
         next_pc = {jalr_tgt_i[31:1], 1'b0};
      else if (UJE_i || (BE_i && br_taken_i))
         next_pc = pc_q + imm_i;
      else
         next_pc = pc_q + 32'd4;
   end

   // Offset from RESET_PC wraps modulo 2^32, so targets below the base fault too.
   assign pc_off   = next_pc - RESET_PC;
   assign next_bad = (next_pc[1:0] != 2'b00) || (pc_off >= PC_SPAN);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ptr_d   = ptr_q;
      mem_we  = 1'b0;
      mem_re  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (iwr_en_i) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end else if (run_i) begin
               state_d = ST_FETCH;
               pc_d    = RESET_PC;
            end
         end
         ST_LOAD: begin
            if (!iwr_en_i) begin
               state_d = ST_FETCH;
               pc_d    = RESET_PC;
            end else if (iwr_valid_i && (ptr_q != PTR_END)) begin
               mem_we = 1'b1;
               ptr_d  = ptr_q + 1'b1;
            end
         end
         ST_FETCH: begin
            mem_re  = 1'b1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (!stall_i) begin
               if (next_bad) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_FETCH;
                  pc_d    = next_pc;
               end
            end
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge cntrst_i) begin
      if (!cntrst_i) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ptr_q   <= ptr_d;
      end
   end

   instr_mem #(
      .IMEM_DEPTH (IMEM_DEPTH)
   ) u_mem (
      .clk_i     (clk_i),
      .cntrst_i  (cntrst_i),
      .wr_en_i   (mem_we),
      .wr_addr_i (ptr_q[AW-1:0]),
      .wr_data_i (iwr_data_i),
      .rd_en_i   (mem_re),
      .rd_addr_i (pc_q[AW+1:2]),
      .rd_data_o (instr_o)
   );

   assign pc_o          = pc_q;
   assign pc_plus4_o    = pc_q + 32'd4;
   assign opcode_o      = instr_o[6:0];
   assign func3_o       = instr_o[14:12];
   assign func7_o       = instr_o[31:25];
   assign rd_o          = instr_o[11:7];
   assign rs1_o         = instr_o[19:15];
   assign rs2_o         = instr_o[24:20];
   assign instr_valid_o = (state_q == ST_EXEC);
   assign fault_o       = (state_q == ST_FAULT);
   assign load_full_o   = (ptr_q == PTR_END);

endmodule
